m_axi_read_throttle: RTL and testbench

- Read-side counterpart of the m_axi write throttle; sits between the kernel read port (TOP) and the AXI bus (BUS).
- Issues AR bursts to BUS only when the local R buffer has reserved space for the whole burst, so RREADY never back-pressures the interconnect.
- Caps the number of outstanding read bursts.
- Buffers R beats and hands them to TOP in order.

---
 rtl/m_axi_throttle_pkg.sv | 35 +++
 rtl/m_axi_sync_fifo.sv | 50 +++++
 rtl/m_axi_read_throttle.sv | 148 ++++++++++++++
 tb/tb_m_axi_read_throttle.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/m_axi_throttle_pkg.sv
// Shared helpers for the m_axi read/write throttles: width calculations and
// FIFO entry widths derived from the block parameters.
package m_axi_throttle_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Counters hold 0..N inclusive, hence the extra bit.
  function automatic int credit_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic int outs_w(input int maxreqs);
    return clog2(maxreqs) + 1;
  endfunction

  function automatic int rbuf_w(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int ar_w(input int addr_width);
    return addr_width + 8;
  endfunction

  localparam int DEF_DEPTH    = 16;
  localparam int DEF_MAXREQS  = 16;
  localparam int DEF_CREDIT_W = credit_w(DEF_DEPTH);
  localparam int DEF_OUTS_W   = outs_w(DEF_MAXREQS);

endpackage

// File: rtl/m_axi_sync_fifo.sv
// Synchronous FIFO with registered storage, full_n/empty_n flags and
// same-cycle push/pop (including push into a full FIFO that is being popped).
module m_axi_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full_n,
  output logic                  empty_n
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  push, pop;

  assign pop     = rd_en & empty_n;
  assign push    = wr_en & (full_n | pop);
  assign full_n  = (count != (ADDR_WIDTH+1)'(DEPTH));
  assign empty_n = (count != '0);
  assign rd_data = mem[rptr];

  always_ff @(posedge clk)
    if (reset_n && clk_en && push) mem[wptr] <= wr_data;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clk_en) begin
      if (push) wptr <= wptr + ADDR_WIDTH'(1);
      if (pop)  rptr <= rptr + ADDR_WIDTH'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/m_axi_read_throttle.sv
// AXI read throttle: issues AR bursts only against reserved R-buffer credit and
// caps outstanding bursts. Optional counters under M_AXI_READ_THROTTLE_STATS_EN.
module m_axi_read_throttle
  import m_axi_throttle_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int MAXREQS    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic [ADDR_WIDTH-1:0] in_TOP_ARADDR,
  input  logic [7:0]            in_TOP_ARLEN,
  input  logic                  in_TOP_ARVALID,
  output logic                  out_TOP_ARREADY,
  output logic [DATA_WIDTH-1:0] out_TOP_RDATA,
  output logic                  out_TOP_RLAST,
  output logic                  out_TOP_RVALID,
  input  logic                  in_TOP_RREADY,
  output logic [ADDR_WIDTH-1:0] out_BUS_ARADDR,
  output logic [7:0]            out_BUS_ARLEN,
  output logic                  out_BUS_ARVALID,
  input  logic                  in_BUS_ARREADY,
  input  logic [DATA_WIDTH-1:0] in_BUS_RDATA,
  input  logic                  in_BUS_RLAST,
  input  logic                  in_BUS_RVALID,
`ifdef M_AXI_READ_THROTTLE_STATS_EN
  output logic [31:0]           stat_ar_stall_cycles,
  output logic [31:0]           stat_bursts_issued,
`endif
  output logic                  out_BUS_RREADY
);

  localparam int CW = credit_w(DEPTH);
  localparam int OW = outs_w(MAXREQS);
  localparam int RW = rbuf_w(DATA_WIDTH);
  localparam int AW = ar_w(ADDR_WIDTH);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
  localparam logic [OW-1:0] OUTS_MAX   = OW'(MAXREQS);
  localparam logic [8:0]    DEPTH9     = 9'(DEPTH);

  logic [AW-1:0]         ar_head;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [7:0]            head_len;
  logic                  ar_full_n, ar_empty_n;
  logic [RW-1:0]         r_head;
  logic                  r_full_n, r_empty_n;

  logic                  ar_valid;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [CW-1:0]         credit, req, credit_next;
  logic [CW:0]           credit_sum;
  logic [OW-1:0]         outstanding;
  logic [8:0]            need;
  logic                  hold_free, issue_ok, ar_pop, r_take, rlast_hs;

  assign {head_len, head_addr} = ar_head;

  // Oversize bursts reserve the whole buffer; RREADY covers the remainder.
  assign need      = {1'b0, head_len} + 9'd1;
  assign req       = (need > DEPTH9) ? CREDIT_MAX : need[CW-1:0];
  assign hold_free = ~ar_valid | in_BUS_ARREADY;
  assign issue_ok  = hold_free & (credit >= req) & (outstanding < OUTS_MAX);
  assign ar_pop    = ar_empty_n & issue_ok;
  assign r_take    = r_empty_n & in_TOP_RREADY;
  assign rlast_hs  = in_BUS_RVALID & r_full_n & in_BUS_RLAST;

  assign credit_sum  = {1'b0, credit} - {1'b0, (ar_pop ? req : '0)}
                     + {{CW{1'b0}}, r_take};
  assign credit_next = (credit_sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX
                                                          : credit_sum[CW-1:0];

  m_axi_sync_fifo #(.DATA_WIDTH(AW), .ADDR_WIDTH(clog2(MAXREQS)), .DEPTH(MAXREQS)) u_ar_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .wr_en   (in_TOP_ARVALID & ar_full_n),
    .wr_data ({in_TOP_ARLEN, in_TOP_ARADDR}),
    .rd_en   (ar_pop),
    .rd_data (ar_head),
    .full_n  (ar_full_n),
    .empty_n (ar_empty_n)
  );

  m_axi_sync_fifo #(.DATA_WIDTH(RW), .ADDR_WIDTH(clog2(DEPTH)), .DEPTH(DEPTH)) u_r_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .wr_en   (in_BUS_RVALID & r_full_n),
    .wr_data ({in_BUS_RLAST, in_BUS_RDATA}),
    .rd_en   (in_TOP_RREADY),
    .rd_data (r_head),
    .full_n  (r_full_n),
    .empty_n (r_empty_n)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ar_valid    <= 1'b0;
      ar_addr     <= '0;
      ar_len      <= '0;
      credit      <= CREDIT_MAX;
      outstanding <= '0;
    end else if (clk_en) begin
      if (ar_pop) begin
        ar_valid <= 1'b1;
        ar_addr  <= head_addr;
        ar_len   <= head_len;
      end else if (in_BUS_ARREADY) begin
        ar_valid <= 1'b0;
      end
      credit <= credit_next;
      unique case ({ar_pop, rlast_hs})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: ;
      endcase
    end
  end

  // Reservation is gated by credit >= req, so the sum can never go negative.
  always_ff @(posedge clk)
    if (reset_n && clk_en) assert (!credit_sum[CW]);

`ifdef M_AXI_READ_THROTTLE_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_ar_stall_cycles <= '0;
      stat_bursts_issued   <= '0;
    end else if (clk_en) begin
      if (ar_empty_n & ~issue_ok)      stat_ar_stall_cycles <= stat_ar_stall_cycles + 32'd1;
      if (ar_valid & in_BUS_ARREADY)   stat_bursts_issued   <= stat_bursts_issued + 32'd1;
    end
  end
`endif

  assign out_TOP_ARREADY = ar_full_n;
  assign out_TOP_RVALID  = r_empty_n;
  assign {out_TOP_RLAST, out_TOP_RDATA} = r_head;
  assign out_BUS_ARVALID = ar_valid;
  assign out_BUS_ARADDR  = ar_addr;
  assign out_BUS_ARLEN   = ar_len;
  assign out_BUS_RREADY  = r_full_n;

endmodule

// File: tb/tb_m_axi_read_throttle.sv
// Randomised + directed bench for m_axi_read_throttle with a transaction-level
// scoreboard, reservation/outstanding bookkeeping and an AXI slave model.
module tb_m_axi_read_throttle;
  localparam int AW = 32, DW = 32, DEPTH = 16, MAXREQS = 2;

  logic          clk = 1'b0, reset_n = 1'b0, clk_en = 1'b1;
  logic [AW-1:0] in_TOP_ARADDR = '0;
  logic [7:0]    in_TOP_ARLEN = '0;
  logic          in_TOP_ARVALID = 1'b0, out_TOP_ARREADY;
  logic [DW-1:0] out_TOP_RDATA;
  logic          out_TOP_RLAST, out_TOP_RVALID, in_TOP_RREADY = 1'b0;
  logic [AW-1:0] out_BUS_ARADDR;
  logic [7:0]    out_BUS_ARLEN;
  logic          out_BUS_ARVALID, in_BUS_ARREADY = 1'b0;
  logic [DW-1:0] in_BUS_RDATA = '0;
  logic          in_BUS_RLAST = 1'b0, in_BUS_RVALID = 1'b0, out_BUS_RREADY;

  m_axi_read_throttle #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAXREQS(MAXREQS)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .in_TOP_ARADDR(in_TOP_ARADDR), .in_TOP_ARLEN(in_TOP_ARLEN),
    .in_TOP_ARVALID(in_TOP_ARVALID), .out_TOP_ARREADY(out_TOP_ARREADY),
    .out_TOP_RDATA(out_TOP_RDATA), .out_TOP_RLAST(out_TOP_RLAST),
    .out_TOP_RVALID(out_TOP_RVALID), .in_TOP_RREADY(in_TOP_RREADY),
    .out_BUS_ARADDR(out_BUS_ARADDR), .out_BUS_ARLEN(out_BUS_ARLEN),
    .out_BUS_ARVALID(out_BUS_ARVALID), .in_BUS_ARREADY(in_BUS_ARREADY),
    .in_BUS_RDATA(in_BUS_RDATA), .in_BUS_RLAST(in_BUS_RLAST),
    .in_BUS_RVALID(in_BUS_RVALID), .out_BUS_RREADY(out_BUS_RREADY)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int len; } ar_t;
  typedef struct { logic [31:0] data; logic last; } beat_t;

  ar_t   exp_ar[$], bus_q[$];
  beat_t exp_r[$];
  int n_chk = 0, n_err = 0;
  int bus_beat = 0, n_bus_ar = 0, reserved = 0, outs = 0, pend_rel = 0, pend_rlast = 0;
  int ar_prob = 100, r_prob = 100, base = 0;
  bit r_en = 1, ar_low = 0, oversize = 0;
  bit prev_arv = 0, prev_arhs = 0, hold_chk = 0;
  logic [31:0] hold_addr = '0;
  logic [7:0]  hold_len = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive slave, account for the edge, wait to the next negedge.
  task automatic cycle();
    bit top_ar, bus_ar, bus_r, top_r, new_ar;
    int req;
    ar_t a;
    beat_t b;
    in_BUS_ARREADY = !ar_low && ($urandom_range(99) < ar_prob);
    if (reset_n && r_en && bus_q.size() > 0 && $urandom_range(99) < r_prob) begin
      in_BUS_RVALID = 1'b1;
      in_BUS_RDATA  = bus_q[0].addr + 32'(bus_beat);
      in_BUS_RLAST  = (bus_beat == bus_q[0].len);
    end else begin
      in_BUS_RVALID = 1'b0;
      in_BUS_RDATA  = $urandom;
      in_BUS_RLAST  = 1'($urandom_range(1));
    end
    if (!reset_n) begin
      exp_ar.delete(); exp_r.delete(); bus_q.delete();
      bus_beat = 0; reserved = 0; outs = 0; pend_rel = 0; pend_rlast = 0;
      prev_arv = 0; prev_arhs = 0; hold_chk = 0;
    end else begin
      if (hold_chk) begin
        chk("ar_hold_valid", out_BUS_ARVALID, 1);
        chk("ar_hold_addr", out_BUS_ARADDR, hold_addr);
        chk("ar_hold_len", out_BUS_ARLEN, hold_len);
      end
      new_ar = out_BUS_ARVALID && (!prev_arv || prev_arhs);
      if (new_ar) begin
        req = int'(out_BUS_ARLEN) + 1;
        if (req > DEPTH) req = DEPTH;
        chk("credit_rule", (reserved + req <= DEPTH), 1);
        chk("outstanding_rule", (outs < MAXREQS), 1);
        reserved += req;
        outs++;
      end
      reserved -= pend_rel;
      if (reserved < 0) reserved = 0;
      outs -= pend_rlast;
      top_ar = clk_en && in_TOP_ARVALID && out_TOP_ARREADY;
      bus_ar = clk_en && out_BUS_ARVALID && in_BUS_ARREADY;
      bus_r  = clk_en && in_BUS_RVALID && out_BUS_RREADY;
      top_r  = clk_en && out_TOP_RVALID && in_TOP_RREADY;
      pend_rel   = top_r;
      pend_rlast = bus_r && in_BUS_RLAST;
      if (top_ar) begin
        a.addr = in_TOP_ARADDR; a.len = int'(in_TOP_ARLEN);
        exp_ar.push_back(a);
        for (int i = 0; i <= a.len; i++) begin
          b.data = a.addr + 32'(i); b.last = (i == a.len);
          exp_r.push_back(b);
        end
      end
      if (bus_ar) begin
        if (exp_ar.size() == 0) chk("ar_spurious", 1, 0);
        else begin
          a = exp_ar.pop_front();
          chk("bus_araddr", out_BUS_ARADDR, a.addr);
          chk("bus_arlen", out_BUS_ARLEN, a.len);
        end
        a.addr = out_BUS_ARADDR; a.len = int'(out_BUS_ARLEN);
        bus_q.push_back(a);
        n_bus_ar++;
      end
      if (bus_r) begin
        bus_beat++;
        if (in_BUS_RLAST) begin void'(bus_q.pop_front()); bus_beat = 0; end
      end
      if (top_r) begin
        if (exp_r.size() == 0) chk("r_spurious", 1, 0);
        else begin
          b = exp_r.pop_front();
          chk("top_rdata", out_TOP_RDATA, b.data);
          chk("top_rlast", out_TOP_RLAST, b.last);
        end
      end
      if (!oversize && in_BUS_RVALID) chk("bus_rready", out_BUS_RREADY, 1);
      hold_chk  = out_BUS_ARVALID && !(in_BUS_ARREADY && clk_en);
      hold_addr = out_BUS_ARADDR;
      hold_len  = out_BUS_ARLEN;
      prev_arv  = out_BUS_ARVALID;
      prev_arhs = bus_ar;
    end
    @(negedge clk);
  endtask

  task automatic push_req(input logic [31:0] a, input int l);
    in_TOP_ARVALID = 1'b1; in_TOP_ARADDR = a; in_TOP_ARLEN = 8'(l);
    cycle();
    in_TOP_ARVALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_TOP_ARVALID = 0; in_TOP_RREADY = 1; r_en = 1; ar_low = 0; clk_en = 1;
    ar_prob = 100; r_prob = 100;
    while ((exp_r.size() > 0 || exp_ar.size() > 0) && n < 800) begin cycle(); n++; end
    chk("drain_done", exp_r.size() + exp_ar.size(), 0);
    repeat (2) cycle();
  endtask

  task automatic chk_reset_outputs(input string p);
    chk({p, "_arvalid"}, out_BUS_ARVALID, 0);
    chk({p, "_top_rvalid"}, out_TOP_RVALID, 0);
    chk({p, "_top_arready"}, out_TOP_ARREADY, 1);
    chk({p, "_bus_rready"}, out_BUS_RREADY, 1);
    chk({p, "_araddr"}, out_BUS_ARADDR, 0);
    chk({p, "_arlen"}, out_BUS_ARLEN, 0);
  endtask

  initial begin
    @(negedge clk);
    reset_n = 0; cycle(); cycle(); reset_n = 1;
    chk_reset_outputs("rst");

    // single ARLEN=3 burst, full rate
    in_TOP_RREADY = 1;
    push_req(32'h1000, 3);
    chk("t1_arvalid_pre", out_BUS_ARVALID, 0);
    cycle();
    chk("t1_arvalid_rise", out_BUS_ARVALID, 1);
    chk("t1_araddr", out_BUS_ARADDR, 32'h1000);
    chk("t1_arlen", out_BUS_ARLEN, 3);
    drain();

    // credit exhaustion: third ARLEN=7 waits for 8 TOP pops
    base = n_bus_ar; in_TOP_RREADY = 0;
    push_req(32'h2000, 7); push_req(32'h3000, 7); push_req(32'h4000, 7);
    repeat (30) cycle();
    chk("t2_two_issued", n_bus_ar - base, 2);
    in_TOP_RREADY = 1; repeat (7) cycle(); in_TOP_RREADY = 0; repeat (5) cycle();
    chk("t2_blocked_after7", n_bus_ar - base, 2);
    in_TOP_RREADY = 1; cycle(); in_TOP_RREADY = 0; repeat (3) cycle();
    chk("t2_issued_after8", n_bus_ar - base, 3);
    drain();

    // outstanding cap with bus R withheld
    base = n_bus_ar; r_en = 0; in_TOP_RREADY = 1;
    push_req(32'h5000, 0); push_req(32'h5100, 0); push_req(32'h5200, 0);
    repeat (8) cycle();
    chk("t3_two_issued", n_bus_ar - base, 2);
    chk("t3_third_held", out_BUS_ARVALID, 0);
    r_en = 1; cycle(); r_en = 0;
    chk("t3_held_at_rlast", out_BUS_ARVALID, 0);
    cycle();
    chk("t3_issue_after_rlast", out_BUS_ARVALID, 1);
    chk("t3_addr", out_BUS_ARADDR, 32'h5200);
    drain();

    // ARREADY held low: AR stable, request FIFO fills
    ar_low = 1;
    push_req(32'h6000, 0); push_req(32'h6100, 0); push_req(32'h6200, 0);
    repeat (3) cycle();
    chk("t4_arvalid_held", out_BUS_ARVALID, 1);
    chk("t4_araddr_held", out_BUS_ARADDR, 32'h6000);
    chk("t4_arlen_held", out_BUS_ARLEN, 0);
    chk("t4_top_arready_full", out_TOP_ARREADY, 0);
    push_req(32'h6300, 0);
    chk("t4_still_full", out_TOP_ARREADY, 0);
    drain();

    // oversize ARLEN=31 waits for full credit, RREADY backstop
    oversize = 1; base = n_bus_ar; in_TOP_RREADY = 0;
    push_req(32'h7000, 3); repeat (10) cycle();
    push_req(32'h8000, 31); repeat (20) cycle();
    chk("t5_wait_credit", n_bus_ar - base, 1);
    in_TOP_RREADY = 1; repeat (3) cycle(); in_TOP_RREADY = 0; repeat (5) cycle();
    chk("t5_wait_credit15", n_bus_ar - base, 1);
    in_TOP_RREADY = 1; cycle(); in_TOP_RREADY = 0; repeat (3) cycle();
    chk("t5_issued_full_credit", n_bus_ar - base, 2);
    repeat (25) cycle();
    chk("t5_rready_full", out_BUS_RREADY, 0);
    chk("t5_top_rvalid", out_TOP_RVALID, 1);
    drain();
    oversize = 0;

    // reset in the middle of a burst
    in_TOP_RREADY = 0;
    push_req(32'h9000, 7); repeat (6) cycle();
    reset_n = 0; cycle(); reset_n = 1;
    chk_reset_outputs("t6");
    base = n_bus_ar;
    push_req(32'hA000, 7); push_req(32'hA100, 7); repeat (30) cycle();
    chk("t6_full_credit", n_bus_ar - base, 2);
    drain();

    // random traffic with clock-enable gaps
    ar_prob = 70; r_prob = 70;
    repeat (1500) begin
      in_TOP_ARVALID = ($urandom_range(99) < 40);
      in_TOP_ARADDR  = {16'($urandom_range(65535)), 16'h0};
      in_TOP_ARLEN   = 8'($urandom_range(15));
      in_TOP_RREADY  = ($urandom_range(99) < 60);
      clk_en         = ($urandom_range(99) < 90);
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
